beep_decoder: RTL and testbench

Receive-side counterpart of the tone beeper. It samples an external beep square wave and recovers slot timing from the signal's edges. It then reports the per-frame duty level, meaning the number of high slots in each 8-slot frame. It sits on the audio-input side and drives status logic that needs to know whether a tone is present and at what duty.

---
 rtl/beep_pkg.sv | 13 +
 rtl/beep_sync.sv | 31 +++
 rtl/beep_decoder.sv | 113 +++++++++++
 tb/tb_beep_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Constants shared by the beeper and the beep decoder, so both ends agree
// on slot timing and on the width of the duty count.
package beep_pkg;

  localparam int SLOT_LEN_DEFAULT        = 285;
  localparam int SLOTS_PER_FRAME_DEFAULT = 8;
  localparam int DUTY_W                  = 4;

  function automatic int slot_cnt_w(input int slot_len);
    return (slot_len > 1) ? $clog2(slot_len) : 1;
  endfunction

endpackage

// File: rtl/beep_sync.sv
// Multi-flop synchronizer for the asynchronous beep input, followed by a
// single-cycle edge flag on the synchronized signal.
module beep_sync
  import beep_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beep_in,
  output logic beep_s,
  output logic edge_flag
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], beep_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign beep_s    = sync_reg[SYNC_STAGES-1];
  assign edge_flag = beep_s ^ prev_reg;

endmodule

// File: rtl/beep_decoder.sv
// Recovers slot timing from the edges of a beep square wave and reports the
// number of high slots seen in each frame.
module beep_decoder
  import beep_pkg::*;
#(
  parameter int SLOT_LEN        = SLOT_LEN_DEFAULT,
  parameter int SLOTS_PER_FRAME = SLOTS_PER_FRAME_DEFAULT,
  parameter int TOL             = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              beep_in,
  output logic [DUTY_W-1:0] duty_ones,
  output logic              duty_valid,
  output logic              tone_present,
  output logic              slot_err
);

  localparam int CNT_W = slot_cnt_w(SLOT_LEN);
  localparam int IDX_W = (SLOTS_PER_FRAME > 1) ? $clog2(SLOTS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] MID      = CNT_W'(SLOT_LEN / 2);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] LATE_MAX = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] EARLY    = CNT_W'(SLOT_LEN - TOL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS_PER_FRAME - 1);

  logic              beep_s, edge_flag;
  logic [CNT_W-1:0]  slot_cnt_reg, slot_cnt_next;
  logic [IDX_W-1:0]  slot_idx_reg, slot_idx_next;
  logic [DUTY_W-1:0] ones_acc_reg, ones_acc_next, acc_sum;
  logic [DUTY_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic              sampled_reg, sampled_next;
  logic              frame_done_reg, frame_done_next;
  logic              slot_err_next;
  logic              sample_now, slot_end, frame_end;

  beep_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .beep_in   (beep_in),
    .beep_s    (beep_s),
    .edge_flag (edge_flag)
  );

  always_comb begin
    // One sample per slot: an error restart after mid-slot must not count twice.
    sample_now    = (slot_cnt_reg == MID) && !sampled_reg;
    acc_sum       = ones_acc_reg + DUTY_W'(sample_now && beep_s);
    slot_end      = 1'b0;
    slot_err_next = 1'b0;
    if (edge_flag) begin
      if (slot_cnt_reg <= LATE_MAX) slot_end = 1'b0;
      else if (slot_cnt_reg >= EARLY) slot_end = 1'b1;
      else slot_err_next = 1'b1;
    end else begin
      slot_end = (slot_cnt_reg == LAST);
    end
    frame_end       = slot_end && (slot_idx_reg == LAST_IDX);
    slot_cnt_next   = (edge_flag || slot_end) ? '0 : slot_cnt_reg + CNT_W'(1);
    slot_idx_next   = slot_idx_reg;
    if (slot_end) slot_idx_next = (slot_idx_reg == LAST_IDX) ? '0 : slot_idx_reg + IDX_W'(1);
    sampled_next    = slot_end ? 1'b0 : (sampled_reg | sample_now);
    ones_acc_next   = frame_end ? '0 : acc_sum;
    frame_cnt_next  = frame_end ? acc_sum : frame_cnt_reg;
    frame_done_next = frame_end;
    if (!enable) begin
      slot_cnt_next   = '0;
      slot_idx_next   = '0;
      sampled_next    = 1'b0;
      ones_acc_next   = '0;
      frame_cnt_next  = '0;
      frame_done_next = 1'b0;
      slot_err_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg   <= '0;
      slot_idx_reg   <= '0;
      sampled_reg    <= 1'b0;
      ones_acc_reg   <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
      slot_err       <= 1'b0;
      duty_ones      <= '0;
      duty_valid     <= 1'b0;
      tone_present   <= 1'b0;
    end else begin
      slot_cnt_reg   <= slot_cnt_next;
      slot_idx_reg   <= slot_idx_next;
      sampled_reg    <= sampled_next;
      ones_acc_reg   <= ones_acc_next;
      frame_cnt_reg  <= frame_cnt_next;
      frame_done_reg <= frame_done_next;
      slot_err       <= slot_err_next;
      if (!enable) begin
        duty_ones    <= '0;
        duty_valid   <= 1'b0;
        tone_present <= 1'b0;
      end else begin
        duty_valid <= frame_done_reg;
        if (frame_done_reg) begin
          duty_ones    <= frame_cnt_reg;
          tone_present <= |frame_cnt_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_beep_decoder.sv
// Drives a behavioural beeper into beep_decoder and checks the reported
// frame duty against the count of high beeper slots in each frame.
module tb_beep_decoder;
  import beep_pkg::*;

  localparam int SL = 285;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       beep_in = 1'b0;
  logic [3:0] duty_ones;
  logic       duty_valid, tone_present, slot_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beep_decoder #(.SLOT_LEN(SL), .SLOTS_PER_FRAME(8), .TOL(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .beep_in      (beep_in),
    .duty_ones    (duty_ones),
    .duty_valid   (duty_valid),
    .tone_present (tone_present),
    .slot_err     (slot_err)
  );

  // Observation of the outputs, one cycle count per posedge since run start
  bit mon_on = 1'b0;
  int cyc;
  int err_cnt;
  int v_duty[$];
  int v_tone[$];
  int v_time[$];
  bit lvq[$];

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      cyc++;
      if (duty_valid) begin
        v_duty.push_back(int'(duty_ones));
        v_tone.push_back(int'(tone_present));
        v_time.push_back(cyc);
        $display("frame cyc=%0d duty_ones=%0d tone_present=%0d", cyc, duty_ones, tone_present);
      end
      if (slot_err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_mon();
    v_duty.delete();
    v_tone.delete();
    v_time.delete();
    err_cnt = 0;
    cyc = 0;
    mon_on = 1'b1;
  endtask

  // Beeper: each entry of lvq is held for one slot; boundaries jittered by +/-jit
  task automatic drive_slots(input int offset, input int jit);
    int jp, jn, d;
    jp = (jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0;
    repeat (offset + jp) @(negedge clk);
    for (int k = 0; k < lvq.size(); k++) begin
      beep_in = lvq[k];
      jn = (jit > 0 && k < lvq.size() - 1) ? int'($urandom_range(2 * jit)) - jit : 0;
      d = SL + jn - jp;
      repeat (d) @(negedge clk);
      jp = jn;
    end
  endtask

  task automatic run_pattern(input string tag, input logic [7:0] pa, input int na,
                             input logic [7:0] pb, input int nb, input int offset,
                             input int jit, input int skip, input int exp_err,
                             output int first_t);
    int nf, s;
    lvq.delete();
    for (int k = 0; k < na; k++) lvq.push_back(pa[k % 8]);
    for (int k = 0; k < nb; k++) lvq.push_back(pb[(na + k) % 8]);
    @(negedge clk);
    start_mon();
    enable = 1'b1;
    drive_slots(offset, jit);
    repeat (50) @(negedge clk);
    mon_on = 1'b0;
    nf = (na + nb) / 8;
    chk({tag, " frames"}, v_duty.size(), nf);
    for (int n = skip; n < nf && n < v_duty.size(); n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += int'(lvq[8 * n + k]);
      chk($sformatf("%s duty[%0d]", tag, n), v_duty[n], s);
      chk($sformatf("%s tone[%0d]", tag, n), v_tone[n], int'(s != 0));
    end
    chk({tag, " slot_err count"}, err_cnt, exp_err);
    first_t = (v_time.size() > 0) ? v_time[0] : -1;
    enable  = 1'b0;
    beep_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic glitch_edge(input string tag);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (slot_err) found = 1'b1;
    end
    chk({tag, " slot_err latency"}, found ? n : -1, 3);
    @(posedge clk);
    #1;
    chk({tag, " slot_err width"}, int'(slot_err), 0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset duty_ones", int'(duty_ones), 0);
    chk("reset duty_valid", int'(duty_valid), 0);
    chk("reset tone_present", int'(tone_present), 0);
    chk("reset slot_err", int'(slot_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_pattern("duty2", 8'b0000_1010, 32, 8'b0000_1010, 0, 0, 0, 0, 0, t);
    run_pattern("silence", 8'b0000_0000, 16, 8'b0000_0000, 0, 0, 0, 0, 0, t);
    chk("silence first valid cycle", t, 8 * SL + 1);
    run_pattern("jitter", 8'b0110_1101, 32, 8'b0110_1101, 0, 100, 3, 1, 1, t);
    run_pattern("change", 8'b0000_0001, 20, 8'b0011_1100, 20, 0, 0, 0, 0, t);
    run_pattern("full", 8'b1111_1111, 16, 8'b1111_1111, 0, 0, 0, 0, 0, t);

    // Isolated glitch pulse starting 140 cycles into a slot
    @(negedge clk);
    start_mon();
    enable = 1'b1;
    repeat (140) @(negedge clk);
    beep_in = 1'b1;
    glitch_edge("glitch rise");
    repeat (30) @(negedge clk);
    beep_in = 1'b0;
    glitch_edge("glitch fall");
    repeat (300) @(negedge clk);
    mon_on = 1'b0;
    chk("glitch slot_err count", err_cnt, 2);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    // Enable dropped in slot 5 of the second frame
    @(negedge clk);
    enable  = 1'b1;
    beep_in = 1'b1;
    repeat (13 * SL) @(negedge clk);
    chk("pre-drop duty_ones", int'(duty_ones), 8);
    chk("pre-drop tone_present", int'(tone_present), 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop duty_ones", int'(duty_ones), 0);
    chk("drop tone_present", int'(tone_present), 0);
    chk("drop duty_valid", int'(duty_valid), 0);
    @(negedge clk);
    start_mon();
    repeat (600) @(negedge clk);
    chk("no valid while disabled", v_duty.size(), 0);
    start_mon();
    enable = 1'b1;
    repeat (8 * SL + 200) @(negedge clk);
    mon_on = 1'b0;
    t = (v_time.size() > 0) ? v_time[0] : -1;
    chk("re-enable first valid cycle", t, 8 * SL + 1);
    t = (v_duty.size() > 0) ? v_duty[0] : -1;
    chk("re-enable duty_ones", t, 8);

    // Asynchronous reset mid-cycle, mid-frame
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    beep_in = 1'b0;
    #1;
    chk("async reset duty_ones", int'(duty_ones), 0);
    chk("async reset tone_present", int'(tone_present), 0);
    chk("async reset duty_valid", int'(duty_valid), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_mon();
    enable = 1'b1;
    repeat (8 * SL + 100) @(negedge clk);
    mon_on = 1'b0;
    t = (v_time.size() > 0) ? v_time[0] : -1;
    chk("post-reset first valid cycle", t, 8 * SL + 1);
    t = (v_tone.size() > 0) ? v_tone[0] : -1;
    chk("post-reset tone_present", t, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
